// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
//   Sequential radix-4 Booth partial-product decoder/accumulator. Takes the
//   per-digit select(x1)/double(x2)/negate triplets of a signed multiplier plus
//   a signed multiplicand. It forms one partial product per clock, MSB digit
//   first, and returns the 2*WIDTH-bit signed product over valid/ready.
//
//   Optional feature macro: BOOTH_DIGIT_CHECK_EN
//     When defined, err flags any processed digit with s&d both set. The flag
//     is sticky until the next acceptance. When undefined, err is tied low.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   b                    signed multiplicand, WIDTH bits
//   s, d, n              per-digit select x1 / select x2 / negate, WIDTH/2 bits
//   out_valid/out_ready  product handshake (out_valid high only in DONE)
//   p                    signed product, 2*WIDTH bits
//   busy                 high while digits are being accumulated (RUN)
//   err                  illegal-digit flag
module booth_pp_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH/2-1:0]   s,
  input  logic [WIDTH/2-1:0]   d,
  input  logic [WIDTH/2-1:0]   n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy,
  output logic                 err
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW     = WIDTH + 2;
  localparam int AW     = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [WIDTH-1:0]    b_q;
  logic [DIGITS-1:0]   s_q, d_q, n_q;

  logic                accept;
  logic                first;
  logic                sel_s, sel_d, sel_n;
  logic [PW-1:0]       mag, pp;
  logic [AW-1:0]       pp_ext, acc_base, acc_sum;

  assign accept = (state_q == IDLE) && in_valid;

  // Digit decode. d wins over s, so an illegal s=d=1 digit still means x2.
  assign sel_s = s_q[cnt_q];
  assign sel_d = d_q[cnt_q];
  assign sel_n = n_q[cnt_q];

  always_comb begin
    mag = '0;
    if (sel_d)      mag = {b_q[WIDTH-1], b_q, 1'b0};
    else if (sel_s) mag = {{2{b_q[WIDTH-1]}}, b_q};
  end

  // Invert plus one: a zero magnitude wraps back to zero, so "negative zero"
  // digits contribute nothing.
  assign pp     = sel_n ? (~mag + PW'(1)) : mag;
  assign pp_ext = {{(AW-PW){pp[PW-1]}}, pp};

  // The accumulator is cleared on the first RUN cycle rather than at the
  // acceptance edge. This keeps p holding the previous product through IDLE
  // and the acceptance edge. The product value is the same either way.
  assign first    = (cnt_q == CW'(DIGITS - 1));
  assign acc_base = first ? '0 : acc_q;
  assign acc_sum  = (acc_base << 2) + pp_ext;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (accept) begin
        b_q <= b;
        s_q <= s;
        d_q <= d;
        n_q <= n;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        cnt_d   = CW'(DIGITS - 1);
      end
      RUN: begin
        acc_d = acc_sum;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: registered state only, no input-to-output paths.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign p = acc_q;

`ifdef BOOTH_DIGIT_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept)                                     err_d = 1'b0;
    else if ((state_q == RUN) && sel_s && sel_d)    err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
